// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin sharing of the register bank command port, plus a whole-bank clear sweep
module regfile_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_rvalid,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_rvalid,
  output logic [1:0]        rf_enab,
  output logic [ADDR_W-1:0] rf_seg,
  output logic [DATA_W-1:0] rf_datain,
  input  logic [DATA_W-1:0] rf_dataout
);
  typedef enum logic [1:0] {IDLE, CMD, RD, CLR} state_t;
  state_t state;
  logic last_grant;
  logic owner;
  logic win;
  // with both ports asking, the one not served last time wins; otherwise whoever asks
  assign win = (r0_req && r1_req) ? ~last_grant : r1_req;
  // sequencer: grants, bank commands, read capture and the clear sweep, all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      rf_enab    <= 2'b11;
      rf_seg     <= '0;
      rf_datain  <= '0;
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
      r0_rvalid  <= 1'b0;
      r1_rvalid  <= 1'b0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
      clr_busy   <= 1'b0;
    end else begin
      r0_ack    <= 1'b0;
      r1_ack    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLR;
            rf_enab  <= 2'b00;
            rf_seg   <= '0;
            clr_busy <= 1'b1;
          end else if (r0_req || r1_req) begin
            state      <= CMD;
            owner      <= win;
            last_grant <= win;
            rf_enab    <= (win ? r1_we : r0_we) ? 2'b01 : 2'b10;
            rf_seg     <= win ? r1_addr : r0_addr;
            rf_datain  <= win ? r1_wdata : r0_wdata;
            r0_ack     <= ~win;
            r1_ack     <= win;
          end
        end
        CMD: begin
          state   <= rf_enab[1] ? RD : IDLE;
          rf_enab <= 2'b11;
        end
        RD: begin
          state <= IDLE;
          if (owner) begin
            r1_rdata  <= rf_dataout;
            r1_rvalid <= 1'b1;
          end else begin
            r0_rdata  <= rf_dataout;
            r0_rvalid <= 1'b1;
          end
        end
        CLR: begin
          if (rf_seg == ADDR_W'(DEPTH - 1)) begin
            state    <= IDLE;
            rf_enab  <= 2'b11;
            clr_busy <= 1'b0;
          end else begin
            rf_seg <= rf_seg + ADDR_W'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: regfile_arbiter against a transaction-level schedule model with a behavioural bank
module tb_regfile_arbiter;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } txn_t;
  typedef struct { int at; bit p; logic [DW-1:0] d; } rv_t;

  logic clk = 1'b0, reset = 1'b1, clr_req = 1'b0, clr_busy;
  logic r0_req = 1'b0, r0_we = 1'b0, r0_ack, r0_rvalid;
  logic r1_req = 1'b0, r1_we = 1'b0, r1_ack, r1_rvalid;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0, rf_seg;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0, r0_rdata, r1_rdata, rf_datain;
  logic [DW-1:0] rf_dataout = '0;
  logic [1:0] rf_enab;

  always #5 clk = ~clk;

  regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clr_req(clr_req), .clr_busy(clr_busy),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid),
    .rf_enab(rf_enab), .rf_seg(rf_seg), .rf_datain(rf_datain), .rf_dataout(rf_dataout)
  );

  // the register bank itself: clear/write at the edge, registered read data
  logic [DW-1:0] bank [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    if (rf_enab == 2'b00) bank[rf_seg] <= '0;
    else if (rf_enab == 2'b01) bank[rf_seg] <= rf_datain;
    if (rf_enab == 2'b10) rf_dataout <= bank[rf_seg];
  end

  int n_chk = 0, n_err = 0;
  int e = 0, free_at = 1, clr_start = -100;
  bit last_g = 1'b1;
  logic [DW-1:0] mem [DEPTH] = '{default: '0};
  logic [DW-1:0] exp_rd [2] = '{default: '0};
  rv_t rvq[$];
  txn_t q0[$], q1[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_enab"}, rf_enab, 2'b11);
    chk({tag, "_seg"}, rf_seg, 0);
    chk({tag, "_datain"}, rf_datain, 0);
    chk({tag, "_acks"}, {r0_ack, r1_ack}, 0);
    chk({tag, "_rvalids"}, {r0_rvalid, r1_rvalid}, 0);
    chk({tag, "_rdata0"}, r0_rdata, 0);
    chk({tag, "_rdata1"}, r1_rdata, 0);
    chk({tag, "_clr_busy"}, clr_busy, 0);
  endtask

  function automatic txn_t mk(input bit we, input int addr, input int d);
    txn_t t;
    t.we = we;
    t.addr = AW'(addr);
    t.wdata = DW'(d);
    return t;
  endfunction

  // one clock: requesters present their queue heads, then the schedule model predicts every output
  task automatic cycle(input bit clr);
    txn_t t;
    rv_t rv;
    bit w;
    logic [1:0] ee;
    bit ea0, ea1, erv0, erv1;
    r0_req = q0.size() > 0;
    if (r0_req) {r0_we, r0_addr, r0_wdata} = q0[0];
    r1_req = q1.size() > 0;
    if (r1_req) {r1_we, r1_addr, r1_wdata} = q1[0];
    clr_req = clr;
    @(posedge clk);
    e++;
    @(negedge clk);
    ea0 = 0; ea1 = 0; ee = 2'b11;
    if (e >= free_at) begin
      if (clr) begin
        clr_start = e;
        free_at = e + DEPTH + 1;
        foreach (mem[i]) mem[i] = '0;
      end else if (r0_req || r1_req) begin
        w = (r0_req && r1_req) ? !last_g : r1_req;
        last_g = w;
        if (w) t = q1.pop_front();
        else t = q0.pop_front();
        ea0 = !w; ea1 = w;
        ee = t.we ? 2'b01 : 2'b10;
        chk("grant_seg", rf_seg, t.addr);
        chk("grant_datain", rf_datain, t.wdata);
        if (t.we) begin
          mem[t.addr] = t.wdata;
          free_at = e + 2;
        end else begin
          rvq.push_back('{e + 2, w, mem[t.addr]});
          free_at = e + 3;
        end
      end
    end
    if (e >= clr_start && e < clr_start + DEPTH) begin
      ee = 2'b00;
      chk("clr_seg", rf_seg, e - clr_start);
    end
    erv0 = 0; erv1 = 0;
    if (rvq.size() > 0 && rvq[0].at == e) begin
      rv = rvq.pop_front();
      if (rv.p) begin erv1 = 1; exp_rd[1] = rv.d; end
      else begin erv0 = 1; exp_rd[0] = rv.d; end
    end
    chk("enab", rf_enab, ee);
    chk("clr_busy", clr_busy, ee == 2'b00);
    chk("ack0", r0_ack, ea0);
    chk("ack1", r1_ack, ea1);
    chk("rvalid0", r0_rvalid, erv0);
    chk("rvalid1", r1_rvalid, erv1);
    chk("rdata0", r0_rdata, exp_rd[0]);
    chk("rdata1", r1_rdata, exp_rd[1]);
  endtask

  function automatic bit busy();
    return q0.size() > 0 || q1.size() > 0 || rvq.size() > 0 || e + 1 < free_at;
  endfunction

  task automatic drain();
    for (int i = 0; i < 80 && busy(); i++) cycle(1'b0);
    chk("drain_timeout", busy(), 0);
  endtask

  initial begin
    @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    // both ports from reset: port 0 first, then strict alternation
    q0.push_back(mk(1, 5, 8'hA7)); q0.push_back(mk(0, 5, 0));
    q0.push_back(mk(1, 3, 8'h3C)); q0.push_back(mk(0, 3, 0));
    q1.push_back(mk(1, 1, 8'h11)); q1.push_back(mk(0, 1, 0));
    q1.push_back(mk(1, 6, 8'h66)); q1.push_back(mk(0, 6, 0));
    drain();
    // clear together with an r1 write, plus a second clear pulse mid-sweep
    q1.push_back(mk(1, 2, 8'h55));
    cycle(1'b1);
    cycle(1'b0); cycle(1'b0); cycle(1'b0);
    cycle(1'b1);
    q1.push_back(mk(0, 2, 0)); q1.push_back(mk(0, 3, 0));
    drain();
    // single requester, back-to-back reads of every register
    for (int a = 0; a < DEPTH; a++) q1.push_back(mk(0, a, 0));
    drain();
    // reset while a read is on the bank port: no rvalid may follow
    q0.push_back(mk(0, 5, 0));
    cycle(1'b0);
    reset = 1'b1;
    #1;
    chk_reset_vals("mid_reset");
    r0_req = 0; r1_req = 0; clr_req = 0;
    q0.delete(); q1.delete(); rvq.delete();
    @(posedge clk);
    e++;
    @(negedge clk);
    chk_reset_vals("reset_hold");
    reset = 1'b0;
    last_g = 1'b1; free_at = e + 1; clr_start = -100; exp_rd = '{default: '0};
    for (int i = 0; i < 6; i++) cycle(1'b0);
    // random traffic on both ports with occasional clears
    for (int i = 0; i < 2000; i++) begin
      if (q0.size() < 2 && $urandom_range(2) == 0)
        q0.push_back(mk($urandom_range(1), $urandom_range(DEPTH - 1), $urandom_range(255)));
      if (q1.size() < 2 && $urandom_range(2) == 0)
        q1.push_back(mk($urandom_range(1), $urandom_range(DEPTH - 1), $urandom_range(255)));
      cycle($urandom_range(40) == 0);
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
